// File: rtl/uart_rx_byte.sv
// UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line.
// Emits a one-cycle data-valid strobe per good frame and a framing-error strobe on a low stop bit.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 1736
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_serial,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_dv,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic             r_rx_d;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [CNT_W-1:0] w_clk_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       r_rx_byte;
  logic [7:0]       w_rx_byte_nxt;
  logic             r_rx_dv;
  logic             w_rx_dv_nxt;
  logic             r_frame_err;
  logic             w_frame_err_nxt;
  logic             w_start_edge;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx_serial;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  assign w_start_edge = r_rx_d & ~r_rx_s;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_rx_byte   <= 8'h00;
      r_rx_dv     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_clk_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_byte   <= w_rx_byte_nxt;
      r_rx_dv     <= w_rx_dv_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state and datapath update; strobes default low so each lasts exactly one cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_clk_cnt_nxt   = r_clk_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_rx_byte_nxt   = r_rx_byte;
    w_rx_dv_nxt     = 1'b0;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clk_cnt_nxt = '0;
        w_bit_idx_nxt = 3'd0;
        if (w_start_edge) begin
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        if (r_clk_cnt == CNT_HALF_END) begin
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = r_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (r_clk_cnt == CNT_BIT_END) begin
          w_clk_cnt_nxt          = '0;
          w_shift_nxt[r_bit_idx] = r_rx_s;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (r_clk_cnt == CNT_BIT_END) begin
          w_clk_cnt_nxt = '0;
          w_state_nxt   = S_CLEANUP;
          if (r_rx_s) begin
            w_rx_byte_nxt = r_shift;
            w_rx_dv_nxt   = 1'b1;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end

      S_CLEANUP: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_rx_byte   = r_rx_byte;
  assign o_rx_dv     = r_rx_dv;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed and random frames against a frame-level model.
module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_byte;
  logic       dv;
  logic       ferr;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Frame-level model state.
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_last = 8'h00;
  int          exp_ferr = 0;
  int          rd_idx   = 0;
  int unsigned start_cyc = 0;

  // Monitor state.
  logic [7:0]  obs_q[$];
  int          ferr_seen   = 0;
  int          overlap     = 0;
  int          wide        = 0;
  logic        prev_dv     = 1'b0;
  logic        prev_ferr   = 1'b0;
  int unsigned cyc         = 0;
  int unsigned last_dv_cyc = 0;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx_serial(rx),
    .o_rx_byte  (rx_byte),
    .o_rx_dv    (dv),
    .o_frame_err(ferr),
    .o_busy     (busy)
  );

  always #30 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv) obs_q.push_back(rx_byte);
    if (dv && !prev_dv) last_dv_cyc <= cyc;
    if (ferr) ferr_seen <= ferr_seen + 1;
    if (dv && ferr) overlap <= overlap + 1;
    if ((dv && prev_dv) || (ferr && prev_ferr)) wide <= wide + 1;
    prev_dv   <= dv;
    prev_ferr <= ferr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame bit-by-bit and records what a correct receiver must report.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (stop) begin
      exp_q.push_back(b);
      exp_last = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    @(posedge clk);
    #1;
    chk({tag, "_dv_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = rd_idx; i < n; i++) begin
      chk({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
    end
    rd_idx = n;
    chk({tag, "_ferr_count"}, 32'(ferr_seen), 32'(exp_ferr));
    chk({tag, "_overlap"}, 32'(overlap), 32'd0);
    chk({tag, "_pulse_width"}, 32'(wide), 32'd0);
    chk({tag, "_held_byte"}, 32'(rx_byte), 32'(exp_last));
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_strobes_idle"}, 32'({dv, ferr}), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  b;
    logic        stop;
    int unsigned lat;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_byte", 32'(rx_byte), 32'h00);
    chk("reset_dv", 32'(dv), 32'd0);
    chk("reset_ferr", 32'(ferr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(20);

    // Single frame, with latency from the falling start edge to the dv strobe.
    send_frame(8'h31, 1'b1);
    idle(40);
    lat = last_dv_cyc - start_cyc;
    chk("latency_in_window", 32'((lat >= 154) && (lat <= 156)), 32'd1);
    check_all("single_31");

    // Back-to-back frames with no idle gap.
    send_frame(8'h30, 1'b1);
    send_frame(8'h31, 1'b1);
    send_frame(8'h30, 1'b1);
    idle(40);
    check_all("back_to_back");

    // Short low glitch must not start a frame.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    check_all("glitch");
    send_frame(8'h31, 1'b1);
    idle(40);
    check_all("after_glitch");

    // Bad stop bit.
    send_frame(8'h55, 1'b0);
    idle(40);
    check_all("frame_err");

    // Reset in the middle of data bit 4.
    b  = 8'hA5;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    chk("busy_mid_frame", 32'(busy), 32'd1);
    #7;
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk("async_rst_byte", 32'(rx_byte), 32'h00);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_strobes", 32'({dv, ferr}), 32'd0);
    exp_last = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(200);
    check_all("post_reset_quiet");
    send_frame(8'hA5, 1'b1);
    idle(40);
    check_all("post_reset_a5");

    // Boundary data.
    send_frame(8'h00, 1'b1);
    idle(40);
    check_all("zero_byte");
    send_frame(8'hFF, 1'b1);
    idle(40);
    check_all("ff_byte");

    // Random bytes, random stop quality, random gaps.
    for (int k = 0; k < 12; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      idle(stop ? int'($urandom_range(0, 12)) : CPB + int'($urandom_range(0, 12)));
    end
    idle(40);
    check_all("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
